alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 clock  in  1  system clock; all state changes on its rising edge.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 clear  in  1  synchronous clear strobe from the control FSM.
REQ-005 execute  in  1  one-cycle start strobe from the control FSM.
REQ-006 operator  in  2  operation select: 00 add, 01 subtract, 10 multiply, 11 divide.
REQ-007 a_bcd100, a_bcd10, a_bcd1  in  4 each  operand A digits (hundreds, tens, ones).
REQ-008 a_neg  in  1  operand A sign; 1 means negative.
REQ-009 b_bcd100, b_bcd10, b_bcd1, b_neg  same widths and meaning as the A ports, for operand B.
REQ-010 r_bcd100, r_bcd10, r_bcd1  out  4 each  result digits, registered.
REQ-011 r_neg  out  1  result sign, registered.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 done  out  1  one-cycle completion strobe.
REQ-014 error  out  1  registered error flag covering overflow, divide-by-zero and invalid digit.

Function
REQ-015 States SHALL be IDLE, LOAD, OP, CHECK, CONV and DONE.
REQ-016 IDLE: an execute sampled high SHALL latch the operands and operator and move to LOAD; all other inputs SHALL be ignored.
REQ-017 execute SHALL be ignored in every state other than IDLE, with no queueing.
REQ-018 LOAD (1 cycle): each operand SHALL be converted to a 10-bit magnitude as d100*100 + d10*10 + d1.
REQ-019 LOAD: any input digit greater than 9, or operator 11 with |B| = 0, SHALL set error and go directly to DONE.
REQ-020 OP, add and subtract: 1 cycle of signed-magnitude arithmetic; subtraction negates B's sign.
REQ-021 OP, multiply: 10 cycles of shift-add on |B| bits, LSB first, into a 20-bit product.
REQ-022 OP, divide: 10 cycles of restoring division, giving a quotient truncated toward zero; the remainder SHALL be discarded.
REQ-023 Result sign for multiply and divide SHALL be a_neg XOR b_neg.
REQ-024 Any zero result SHALL force r_neg = 0, so there is no -000.
REQ-025 CHECK (1 cycle): a magnitude greater than 999 SHALL set error and go to DONE; otherwise go to CONV.
REQ-026 CONV: 10 cycles of double-dabble (add 3 to any digit >= 5, then shift), producing 3 BCD digits.
REQ-027 Entering DONE without error: the r_* outputs SHALL load the converted value and error SHALL clear.
REQ-028 Entering DONE with error: the r_* outputs SHALL load 0 with r_neg = 0, and error SHALL be set.
REQ-029 DONE SHALL last exactly 1 cycle with done = 1, then return to IDLE.
REQ-030 The r_* outputs and error SHALL hold their values until the next entry to DONE, or until clear or reset.
REQ-031 Latency, with execute sampled at edge k, is the cycle in which done is high:
- add/sub: k+14
- mul/div: k+23
- CHECK overflow: k+4 for add/sub, k+13 for mul/div
- LOAD error: k+2
REQ-032 clear in any state SHALL:
- return the state to IDLE on the next edge;
- zero the r_* outputs and error;
- suppress done.
REQ-033 clear and execute high in the same cycle: clear SHALL win and execute SHALL be dropped.
REQ-034 Internal datapath widths: magnitudes 10 bits, sum 11 bits, product 20 bits; no intermediate value SHALL wrap.

Reset
REQ-035 reset_n low SHALL immediately force:
- state = IDLE
- busy = 0, done = 0, error = 0
- all r_* outputs = 0
- all internal registers = 0
REQ-036 Release of reset_n SHALL take effect at the next rising clock edge; reset asserted mid-operation SHALL abort it with no done pulse.

Verification
REQ-037 The bench SHALL cover the following directed scenarios:
- 123 + 456 -> done at k+14, result 579, r_neg=0, error=0.
- 005 - 012 -> result 007, r_neg=1; then 012 - 012 -> result 000, r_neg=0.
- -045 * 011 -> done at k+23, result 495, r_neg=1; and 999 * 002 -> done at k+13, error=1, result 000.
- 100 / 007 -> result 014; and 100 / 000 -> done at k+2, error=1.
- A digit of 0xA on a_bcd10 -> error at k+2.
- execute pulsed again while busy -> ignored, and exactly one done pulse.
- clear asserted at k+5 of a multiply -> IDLE at k+6, outputs 0, no done.
- reset_n pulsed low mid-CONV -> immediate IDLE, all outputs 0.

Source files
------------

// File: rtl/alu_sequencer.sv
// Three-digit signed BCD calculator datapath: add, subtract, multiply, divide
// with binary arithmetic in the middle and double-dabble back to BCD.
module alu_sequencer (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clear,
    input  logic       execute,
    input  logic [1:0] operator,
    input  logic [3:0] a_bcd100,
    input  logic [3:0] a_bcd10,
    input  logic [3:0] a_bcd1,
    input  logic       a_neg,
    input  logic [3:0] b_bcd100,
    input  logic [3:0] b_bcd10,
    input  logic [3:0] b_bcd1,
    input  logic       b_neg,
    output logic [3:0] r_bcd100,
    output logic [3:0] r_bcd10,
    output logic [3:0] r_bcd1,
    output logic       r_neg,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int unsigned MAG_W  = 10;
    localparam int unsigned SUM_W  = 11;
    localparam int unsigned PROD_W = 20;
    localparam int unsigned BCD_W  = 12;
    localparam int unsigned CNT_W  = 4;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(9);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_OP, S_CHECK, S_CONV, S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                err_c;
    logic [1:0]          op_q;
    logic [BCD_W-1:0]    a_dig_q, b_dig_q;
    logic                a_neg_q, b_neg_q, res_neg_q;
    logic [PROD_W-1:0]   a_sh_q, acc_q;
    logic [MAG_W-1:0]    b_sh_q, bin_q;
    logic [BCD_W-1:0]    bcd_q;
    logic [CNT_W-1:0]    cnt_q;

    logic [MAG_W-1:0]    a_mag_c, b_mag_c, a_m_c;
    logic                digit_bad_c, div_zero_c, op_last_c, overflow_c;
    logic                b_eff_neg_c, sum_neg_c, q_bit_c;
    logic [SUM_W-1:0]    sum_c, rem_sh_c, rem_next_c;
    logic [PROD_W-1:0]   mag_c;
    logic [BCD_W-1:0]    bcd_adj_c, bcd_next_c;

    function automatic logic [MAG_W-1:0] bcd_to_mag(input logic [BCD_W-1:0] d);
        return MAG_W'(d[11:8]) * MAG_W'(100) + MAG_W'(d[7:4]) * MAG_W'(10) + MAG_W'(d[3:0]);
    endfunction

    function automatic logic digits_bad(input logic [BCD_W-1:0] d);
        return (d[11:8] > 4'd9) || (d[7:4] > 4'd9) || (d[3:0] > 4'd9);
    endfunction

    // Datapath helpers: operand conversion, add/sub, divide step, range check, dabble step
    always_comb begin
        a_mag_c     = bcd_to_mag(a_dig_q);
        b_mag_c     = bcd_to_mag(b_dig_q);
        digit_bad_c = digits_bad(a_dig_q) || digits_bad(b_dig_q);
        div_zero_c  = (op_q == OP_DIV) && (b_mag_c == '0);
        op_last_c   = (op_q == OP_ADD) || (op_q == OP_SUB) || (cnt_q == LAST_STEP);

        a_m_c       = a_sh_q[MAG_W-1:0];
        b_eff_neg_c = b_neg_q ^ (op_q == OP_SUB);
        sum_c       = '0;
        sum_neg_c   = a_neg_q;
        if (a_neg_q == b_eff_neg_c) begin
            sum_c = SUM_W'(a_m_c) + SUM_W'(b_sh_q);
        end else if (a_m_c >= b_sh_q) begin
            sum_c = SUM_W'(a_m_c - b_sh_q);
        end else begin
            sum_c     = SUM_W'(b_sh_q - a_m_c);
            sum_neg_c = b_eff_neg_c;
        end

        rem_sh_c   = {acc_q[MAG_W-1:0], a_sh_q[MAG_W-1]};
        q_bit_c    = rem_sh_c >= SUM_W'(b_sh_q);
        rem_next_c = q_bit_c ? rem_sh_c - SUM_W'(b_sh_q) : rem_sh_c;

        mag_c      = (op_q == OP_DIV) ? PROD_W'(a_sh_q[MAG_W-1:0]) : acc_q;
        overflow_c = mag_c > PROD_W'(999);

        bcd_adj_c = bcd_q;
        for (int i = 0; i < 3; i++) begin
            if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj_c[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
        end
        bcd_next_c = {bcd_adj_c[BCD_W-2:0], bin_q[MAG_W-1]};
    end

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Next-state logic; err_c marks a transition into DONE caused by an error
    always_comb begin
        state_d = state_q;
        err_c   = 1'b0;
        if (clear) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (execute) state_d = S_LOAD;
                S_LOAD: begin
                    if (digit_bad_c || div_zero_c) begin
                        state_d = S_DONE;
                        err_c   = 1'b1;
                    end else begin
                        state_d = S_OP;
                    end
                end
                S_OP:    if (op_last_c) state_d = S_CHECK;
                S_CHECK: begin
                    if (overflow_c) begin
                        state_d = S_DONE;
                        err_c   = 1'b1;
                    end else begin
                        state_d = S_CONV;
                    end
                end
                S_CONV:  if (cnt_q == LAST_STEP) state_d = S_DONE;
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Operand capture, arithmetic iterations and binary-to-BCD shifting
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            op_q      <= '0;
            a_dig_q   <= '0;
            b_dig_q   <= '0;
            a_neg_q   <= 1'b0;
            b_neg_q   <= 1'b0;
            res_neg_q <= 1'b0;
            a_sh_q    <= '0;
            acc_q     <= '0;
            b_sh_q    <= '0;
            bin_q     <= '0;
            bcd_q     <= '0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (state_d == S_LOAD) begin
                        op_q    <= operator;
                        a_dig_q <= {a_bcd100, a_bcd10, a_bcd1};
                        b_dig_q <= {b_bcd100, b_bcd10, b_bcd1};
                        a_neg_q <= a_neg;
                        b_neg_q <= b_neg;
                    end
                end
                S_LOAD: begin
                    a_sh_q    <= PROD_W'(a_mag_c);
                    b_sh_q    <= b_mag_c;
                    acc_q     <= '0;
                    cnt_q     <= '0;
                    res_neg_q <= a_neg_q ^ b_neg_q;
                end
                S_OP: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            acc_q     <= PROD_W'(sum_c);
                            res_neg_q <= sum_neg_c;
                        end
                        OP_DIV: begin
                            acc_q  <= PROD_W'(rem_next_c);
                            a_sh_q <= PROD_W'({a_sh_q[MAG_W-2:0], q_bit_c});
                        end
                        default: begin
                            if (b_sh_q[0]) acc_q <= acc_q + a_sh_q;
                            a_sh_q <= {a_sh_q[PROD_W-2:0], 1'b0};
                            b_sh_q <= {1'b0, b_sh_q[MAG_W-1:1]};
                        end
                    endcase
                end
                S_CHECK: begin
                    bin_q <= mag_c[MAG_W-1:0];
                    bcd_q <= '0;
                    cnt_q <= '0;
                    if (mag_c == '0) res_neg_q <= 1'b0;
                end
                S_CONV: begin
                    bcd_q <= bcd_next_c;
                    bin_q <= {bin_q[MAG_W-2:0], 1'b0};
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Registered status and result outputs, updated on entry to DONE
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 1'b0;
            r_neg    <= 1'b0;
            r_bcd100 <= '0;
            r_bcd10  <= '0;
            r_bcd1   <= '0;
        end else begin
            busy <= (state_d != S_IDLE);
            done <= (state_d == S_DONE);
            if (clear || ((state_d == S_DONE) && err_c)) begin
                r_bcd100 <= '0;
                r_bcd10  <= '0;
                r_bcd1   <= '0;
                r_neg    <= 1'b0;
                error    <= !clear;
            end else if (state_d == S_DONE) begin
                r_bcd100 <= bcd_next_c[11:8];
                r_bcd10  <= bcd_next_c[7:4];
                r_bcd1   <= bcd_next_c[3:0];
                r_neg    <= res_neg_q;
                error    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, scoreboard of expected
// results, and directed sequences for retrigger, clear and reset aborts.
module tb_alu_sequencer;

    localparam int MAX_LAT = 40;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    logic       clock = 1'b0;
    logic       reset_n, clear, execute, a_neg, b_neg;
    logic [1:0] operator;
    logic [3:0] a_bcd100, a_bcd10, a_bcd1, b_bcd100, b_bcd10, b_bcd1;
    logic [3:0] r_bcd100, r_bcd10, r_bcd1;
    logic       r_neg, busy, done, error;

    alu_sequencer dut (
        .clock(clock), .reset_n(reset_n), .clear(clear), .execute(execute),
        .operator(operator),
        .a_bcd100(a_bcd100), .a_bcd10(a_bcd10), .a_bcd1(a_bcd1), .a_neg(a_neg),
        .b_bcd100(b_bcd100), .b_bcd10(b_bcd10), .b_bcd1(b_bcd1), .b_neg(b_neg),
        .r_bcd100(r_bcd100), .r_bcd10(r_bcd10), .r_bcd1(r_bcd1), .r_neg(r_neg),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [11:0] a;
        logic        an;
        logic [11:0] b;
        logic        bn;
        logic [11:0] r;
        logic        rn;
        logic        err;
        int          lat;
    } vec_t;

    typedef struct {
        logic [13:0] res;
        int          lat;
    } exp_t;

    vec_t vecs[16];
    exp_t sb_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    function automatic logic [13:0] outs();
        return {r_bcd100, r_bcd10, r_bcd1, r_neg, error};
    endfunction

    task automatic drive_ops(input vec_t v);
        operator = v.op;
        {a_bcd100, a_bcd10, a_bcd1} = v.a;
        {b_bcd100, b_bcd10, b_bcd1} = v.b;
        a_neg = v.an;
        b_neg = v.bn;
    endtask

    // Drives execute so that it is sampled at edge k; returns at the first cycle after k
    task automatic launch(input vec_t v);
        @(negedge clock);
        drive_ops(v);
        execute = 1'b1;
        @(posedge clock);
        @(negedge clock);
        execute = 1'b0;
    endtask

    task automatic wait_done(output int lat, output bit seen);
        lat  = 1;
        seen = 1'b0;
        while (!seen && lat <= MAX_LAT) begin
            if (done === 1'b1) seen = 1'b1;
            else begin
                @(negedge clock);
                lat++;
            end
        end
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int   lat;
        bit   seen;
        exp_t e;
        sb_q.push_back('{res: {v.r, v.rn, v.err}, lat: v.lat});
        launch(v);
        wait_done(lat, seen);
        e = sb_q.pop_front();
        if (!seen) begin
            check({name, " done timeout"}, 32'd0, 32'd1);
        end else begin
            check({name, " latency"}, 32'(lat), 32'(e.lat));
            check({name, " result"}, 32'(outs()), 32'(e.res));
            @(negedge clock);
            check({name, " done/busy after"}, 32'({done, busy}), 32'd0);
        end
    endtask

    // Counts done pulses over a window of cycles
    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            if (done === 1'b1) n++;
        end
    endtask

    initial begin
        int   lat, nd, first_lat;
        logic [13:0] first_res;
        vec_t bad;

        vecs[0]  = '{OP_ADD, 12'h123, 1'b0, 12'h456, 1'b0, 12'h579, 1'b0, 1'b0, 14};
        vecs[1]  = '{OP_SUB, 12'h005, 1'b0, 12'h012, 1'b0, 12'h007, 1'b1, 1'b0, 14};
        vecs[2]  = '{OP_SUB, 12'h012, 1'b0, 12'h012, 1'b0, 12'h000, 1'b0, 1'b0, 14};
        vecs[3]  = '{OP_MUL, 12'h045, 1'b1, 12'h011, 1'b0, 12'h495, 1'b1, 1'b0, 23};
        vecs[4]  = '{OP_MUL, 12'h999, 1'b0, 12'h002, 1'b0, 12'h000, 1'b0, 1'b1, 13};
        vecs[5]  = '{OP_DIV, 12'h100, 1'b0, 12'h007, 1'b0, 12'h014, 1'b0, 1'b0, 23};
        vecs[6]  = '{OP_DIV, 12'h100, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b1, 2};
        vecs[7]  = '{OP_ADD, 12'h1A3, 1'b0, 12'h001, 1'b0, 12'h000, 1'b0, 1'b1, 2};
        vecs[8]  = '{OP_ADD, 12'h999, 1'b0, 12'h001, 1'b0, 12'h000, 1'b0, 1'b1, 4};
        vecs[9]  = '{OP_SUB, 12'h500, 1'b1, 12'h499, 1'b0, 12'h999, 1'b1, 1'b0, 14};
        vecs[10] = '{OP_DIV, 12'h100, 1'b1, 12'h007, 1'b0, 12'h014, 1'b1, 1'b0, 23};
        vecs[11] = '{OP_MUL, 12'h000, 1'b0, 12'h005, 1'b1, 12'h000, 1'b0, 1'b0, 23};
        vecs[12] = '{OP_DIV, 12'h999, 1'b0, 12'h999, 1'b0, 12'h001, 1'b0, 1'b0, 23};
        vecs[13] = '{OP_ADD, 12'h003, 1'b1, 12'h003, 1'b0, 12'h000, 1'b0, 1'b0, 14};
        vecs[14] = '{OP_DIV, 12'h005, 1'b1, 12'h007, 1'b0, 12'h000, 1'b0, 1'b0, 23};
        vecs[15] = '{OP_MUL, 12'h031, 1'b0, 12'h032, 1'b0, 12'h992, 1'b0, 1'b0, 23};
        bad      = '{OP_DIV, 12'h000, 1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 0};

        reset_n = 1'b0;
        clear   = 1'b0;
        execute = 1'b0;
        drive_ops(vecs[0]);
        repeat (2) @(posedge clock);
        #1;
        check("reset outputs", 32'({outs(), busy, done}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 16; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // execute pulsed again while busy is ignored
        sb_q.push_back('{res: {12'h579, 1'b0, 1'b0}, lat: 14});
        launch(vecs[0]);
        nd = 0; first_lat = 0; first_res = '0;
        for (lat = 1; lat <= MAX_LAT; lat++) begin
            if (lat == 5) begin
                drive_ops(bad);
                execute = 1'b1;
            end else begin
                execute = 1'b0;
            end
            if (done === 1'b1) begin
                nd++;
                if (nd == 1) begin
                    first_lat = lat;
                    first_res = outs();
                end
            end
            @(negedge clock);
        end
        begin
            exp_t e;
            e = sb_q.pop_front();
            check("retrigger done count", 32'(nd), 32'd1);
            check("retrigger latency", 32'(first_lat), 32'(e.lat));
            check("retrigger result", 32'(first_res), 32'(e.res));
        end

        // clear and execute together: clear wins
        @(negedge clock);
        drive_ops(vecs[0]);
        clear   = 1'b1;
        execute = 1'b1;
        @(negedge clock);
        clear   = 1'b0;
        execute = 1'b0;
        check("clear+execute state", 32'({outs(), busy, done}), 32'd0);
        count_done(30, nd);
        check("clear+execute no done", 32'(nd), 32'd0);

        // clear at k+5 of a multiply
        run_vec(vecs[0], "pre-clear");
        launch(vecs[3]);
        repeat (4) @(negedge clock);
        check("busy before clear", 32'(busy), 32'd1);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        check("clear mid-mul", 32'({outs(), busy, done}), 32'd0);
        count_done(30, nd);
        check("clear mid-mul no done", 32'(nd), 32'd0);

        // reset pulse during CONV
        run_vec(vecs[15], "pre-reset");
        launch(vecs[0]);
        repeat (7) @(negedge clock);
        check("busy before reset", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("reset mid-conv", 32'({outs(), busy, done}), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        count_done(30, nd);
        check("reset mid-conv no done", 32'(nd), 32'd0);
        run_vec(vecs[5], "post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
